// File: rtl/jk_sync_counter.sv
// jk_sync_counter
//   Synchronous mod-MODULUS up/down counter built from a bank of per-bit JK
//   cells. The combinational drive stage computes J/K for every cell from the
//   control inputs and the current state; the cells then update on the rising
//   clock edge using the JK rule (hold / clear / set / toggle).
//
// Ports
//   clock     in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   en        in   1      count enable
//   up        in   1      count direction (1 = up, 0 = down)
//   load      in   1      synchronous parallel load of din
//   din       in   WIDTH  load value
//   q         out  WIDTH  counter state (registered cell outputs)
//   qbar      out  WIDTH  complement of q, registered alongside q
//   j_vec     out  WIDTH  J drive applied at the next edge
//   k_vec     out  WIDTH  K drive applied at the next edge
//   tc        out  1      terminal count for cascading
//   load_err  out  1      one-cycle pulse after an out-of-range load
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ALL1  = {WIDTH{1'b1}};

  // JK cell rule applied bitwise: J=1 sets, K=1 clears, both toggles.
  function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] j,
                                               input logic [WIDTH-1:0] k);
    jk_next = (j & ~cur) | (~k & cur);
  endfunction

  logic             din_oor;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;
  logic [WIDTH-1:0] q_nxt;

  // MODULUS may equal 2**WIDTH, so compare with one extra bit of headroom.
  assign din_oor = ({1'b0, din} >= (WIDTH+1)'(MODULUS));
  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

  // Toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic carry;
    logic borrow;
    up_tog = '0;
    dn_tog = '0;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_tog[i] = carry;
      dn_tog[i] = borrow;
      carry     = carry & q[i];
      borrow    = borrow & ~q[i];
    end
  end

  // Drive stage: J/K for the next edge, priority load > en > hold.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (load) begin
      if (din_oor) begin
        j_vec = '0;
        k_vec = ALL1;
      end else begin
        j_vec = din;
        k_vec = ~din;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          j_vec = '0;
          k_vec = ALL1;
        end else begin
          j_vec = up_tog;
          k_vec = up_tog;
        end
      end else begin
        if (at_zero) begin
          j_vec = MAX_Q;
          k_vec = ~MAX_Q;
        end else begin
          j_vec = dn_tog;
          k_vec = dn_tog;
        end
      end
    end
  end

  assign tc    = en & ~load & ~reset & (up ? at_max : at_zero);
  assign q_nxt = jk_next(q, j_vec, k_vec);

  // Cell stage: state only ever changes through the JK rule (or reset).
  always_ff @(posedge clock) begin
    if (reset) begin
      q        <= '0;
      qbar     <= ALL1;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      qbar     <= ~q_nxt;
      load_err <= load & din_oor;
    end
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
module tb_jk_sync_counter;

  localparam int W    = 4;
  localparam int M    = 10;
  localparam int FULL = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         en    = 1'b0;
  logic         up    = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] din   = '0;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic [W-1:0] j_vec;
  logic [W-1:0] k_vec;
  logic         tc;
  logic         load_err;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer count value.
  int mq     = 0;
  int mle    = 0;
  bit mvalid = 1'b0;

  jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .q        (q),
    .qbar     (qbar),
    .j_vec    (j_vec),
    .k_vec    (k_vec),
    .tc       (tc),
    .load_err (load_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check same-cycle outputs, then the
  // registered outputs just after the edge.
  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input logic [W-1:0] d);
    int nq, nle, ej, ek, etc;
    reset = r; en = e; up = u; load = l; din = d;
    nq = mq; nle = 0; ej = 0; ek = 0;
    if (r) begin
      nq = 0;
    end else if (l) begin
      if (int'(d) < M) begin nq = int'(d); ej = int'(d); ek = ~int'(d) & FULL; end
      else begin nq = 0; nle = 1; ej = 0; ek = FULL; end
    end else if (e) begin
      if (u) begin
        nq = (mq + 1) % M;
        if (mq == M - 1) begin ej = 0; ek = FULL; end
        else begin ej = mq ^ nq; ek = ej; end
      end else begin
        nq = (mq + M - 1) % M;
        if (mq == 0) begin ej = M - 1; ek = ~(M - 1) & FULL; end
        else begin ej = mq ^ nq; ek = ej; end
      end
    end
    etc = (e && !l && !r && (u ? (mq == M - 1) : (mq == 0))) ? 1 : 0;
    @(negedge clock);
    if (mvalid) begin
      chk("tc", 32'(tc), 32'(etc));
      if (!r) begin
        chk("j_vec", 32'(j_vec), 32'(ej));
        chk("k_vec", 32'(k_vec), 32'(ek));
      end
    end
    @(posedge clock);
    #1;
    mq = nq; mle = nle; mvalid = 1'b1;
    chk("q", 32'(q), 32'(mq));
    chk("qbar", 32'(qbar), 32'(~mq & FULL));
    chk("load_err", 32'(load_err), 32'(mle));
  endtask

  initial begin
    // Reset with a competing load.
    step(1, 0, 0, 1, 4'd5);
    // Count up through the wrap.
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 4'd0);
    // Count down through the wrap from zero.
    step(0, 1, 0, 0, 4'd0);
    step(0, 1, 0, 0, 4'd0);
    // Legal load with en also high.
    step(0, 1, 1, 1, 4'd7);
    // Illegal load, then a normal cycle to see the pulse drop.
    step(0, 0, 1, 1, 4'd12);
    step(0, 0, 1, 0, 4'd0);
    step(0, 1, 0, 1, 4'd15);
    step(0, 1, 1, 0, 4'd0);
    // Hold at 4, count to 6, reset mid-count.
    step(0, 0, 1, 1, 4'd4);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 4'd0);
    step(0, 1, 1, 0, 4'd0);
    step(0, 1, 1, 0, 4'd0);
    step(1, 1, 1, 0, 4'd0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           4'($urandom_range(0, FULL)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
